// File: rtl/lfsr_range_gen.sv
// Fibonacci LFSR with runtime seed loading and a request/response port that returns range-bounded values.
// Optional build macro LFSR_LOCKUP_GUARD_EN replaces any all-zero load or advance result with 1.
module lfsr_range_gen #(
  parameter int unsigned      WIDTH     = 9,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(9'h011),
  parameter logic [WIDTH-1:0] SEED      = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RANGE_MIN = '0,
  parameter logic [WIDTH-1:0] RANGE_MAX = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_value,
  input  logic             req,
  output logic             req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_value,
  output logic [WIDTH-1:0] lfsr_output
);

  // A zero SEED would lock the register, so reset falls back to 1.
  localparam logic [WIDTH-1:0] RESET_STATE = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [WIDTH-1:0] SPAN        = RANGE_MAX - RANGE_MIN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] rsp_value_q, rsp_value_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] offset;
  logic             in_range;

  function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
    return {^(s & TAPS), s[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] lockup_fix(input logic [WIDTH-1:0] v);
`ifdef LFSR_LOCKUP_GUARD_EN
    return (v == '0) ? WIDTH'(1) : v;
`else
    return v;
`endif
  endfunction

  // Values below RANGE_MIN wrap to above SPAN, so one unsigned compare covers both bounds.
  assign offset   = lfsr_q - RANGE_MIN;
  assign in_range = (offset <= SPAN);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    rsp_value_d = rsp_value_q;
    rsp_valid_d = rsp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (req) state_d = DRAW;
      end
      DRAW: begin
        if (in_range) begin
          state_d     = VALID;
          rsp_value_d = lfsr_q;
          rsp_valid_d = 1'b1;
        end
      end
      VALID: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    // Seed load wins over the DRAW auto-advance, which wins over step; step is dead in DRAW.
    if (seed_load) begin
      lfsr_d = lockup_fix(seed_value);
    end else if (state_q == DRAW) begin
      lfsr_d = lockup_fix(lfsr_advance(lfsr_q));
    end else if (step) begin
      lfsr_d = lockup_fix(lfsr_advance(lfsr_q));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lfsr_q      <= RESET_STATE;
      rsp_value_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      rsp_value_q <= rsp_value_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_value   = rsp_value_q;
  assign lfsr_output = lfsr_q;

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Bench for lfsr_range_gen: vector table, hand-written corner sequences and randomized
// transactions checked against a sequence-walking reference model.
module tb_lfsr_range_gen;

  localparam int           W    = 9;
  localparam logic [W-1:0] TAPS = 9'h011;
  localparam logic [W-1:0] RMIN = 9'h0F0;
  localparam logic [W-1:0] RMAX = 9'h0FF;

  logic         clock = 1'b0;
  logic         reset;
  logic         step;
  logic         seed_load;
  logic [W-1:0] seed_value;
  logic         req;
  logic         req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_value;
  logic [W-1:0] lfsr_output;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  lfsr_range_gen #(
    .WIDTH    (W),
    .TAPS     (TAPS),
    .SEED     ({W{1'b1}}),
    .RANGE_MIN(RMIN),
    .RANGE_MAX(RMAX)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .step       (step),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .req        (req),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_value  (rsp_value),
    .lfsr_output(lfsr_output)
  );

  typedef struct {
    logic         step;
    logic         seed_load;
    logic [W-1:0] seed_value;
    logic         req;
    logic         rsp_ready;
    logic [W-1:0] exp_lfsr;
    logic         exp_valid;
    logic         exp_ready;
    logic [W-1:0] exp_value;
  } vec_t;

  vec_t vecs[15];

  // Reference: the spec's feedback rule as parity of the tapped bits.
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] s);
    int fb;
    fb = $countones(s & TAPS) % 2;
    return {fb[0], s[W-1:1]};
  endfunction

  function automatic logic in_rng(input logic [W-1:0] v);
    return (v >= RMIN) && (v <= RMAX);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    step       = 1'b0;
    seed_load  = 1'b0;
    seed_value = '0;
    req        = 1'b0;
    rsp_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  // Walk from the state seen at the first compare; returns accepted value and reject count.
  task automatic predict(input logic [W-1:0] start, output logic [W-1:0] val, output int rejects);
    val     = start;
    rejects = 0;
    while (!in_rng(val) && rejects < 600) begin
      val = ref_next(val);
      rejects++;
    end
  endtask

  // Wait for rsp_valid with a cycle budget; step is randomly pulsed and must be ignored.
  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 600) begin
      step = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    step = 1'b0;
  endtask

  logic [W-1:0] m;
  logic [W-1:0] v;
  int           k;
  int           cnt;
  int           dups;
  bit           seen[512];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h1FF, 1'b0, 1'b0, 9'h000},
      '{1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0, 9'h000},
      '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 9'h07F, 1'b1, 1'b0, 9'h0FF},
      '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h07F, 1'b1, 1'b0, 9'h0FF},
      '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h07F, 1'b1, 1'b0, 9'h0FF},
      '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h07F, 1'b1, 1'b0, 9'h0FF},
      '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h07F, 1'b1, 1'b0, 9'h0FF},
      '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h07F, 1'b1, 1'b0, 9'h0FF},
      '{1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'h03F, 1'b1, 1'b0, 9'h0FF},
      '{1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 9'h03F, 1'b0, 1'b1, 9'h000},
      '{1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'h01F, 1'b0, 1'b1, 9'h000},
      '{1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'h00F, 1'b0, 1'b1, 9'h000},
      '{1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'h107, 1'b0, 1'b1, 9'h000},
      '{1'b1, 1'b1, 9'h155, 1'b0, 1'b0, 9'h155, 1'b0, 1'b1, 9'h000},
      '{1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'h0AA, 1'b0, 1'b1, 9'h000}
    };

    // Reset state, checked while reset is still asserted
    idle_inputs();
    reset = 1'b1;
    #2;
    chk("reset_lfsr", lfsr_output, 9'h1FF);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_value", rsp_value, 0);
    chk("reset_ready", req_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    #1;

    // Vector table: request scenario, hold, steps, seed load with step
    for (int i = 0; i < 15; i++) begin
      step       = vecs[i].step;
      seed_load  = vecs[i].seed_load;
      seed_value = vecs[i].seed_value;
      req        = vecs[i].req;
      rsp_ready  = vecs[i].rsp_ready;
      tick();
      chk($sformatf("vec%0d_lfsr", i), lfsr_output, vecs[i].exp_lfsr);
      chk($sformatf("vec%0d_valid", i), rsp_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_value", i), rsp_value, vecs[i].exp_value);
    end
    idle_inputs();

    // Full period from reset
    apply_reset();
    m    = 9'h1FF;
    dups = 0;
    for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    seen[9'h1FF] = 1'b1;
    for (int i = 1; i <= 511; i++) begin
      step = 1'b1;
      tick();
      m = ref_next(m);
      chk("period_lfsr", lfsr_output, m);
      if (i < 511) begin
        if (seen[lfsr_output]) dups++;
        seen[lfsr_output] = 1'b1;
      end
    end
    step = 1'b0;
    chk("period_return", lfsr_output, 9'h1FF);
    chk("period_dups", dups, 0);
    chk("period_zero", seen[0], 0);

    // Seed load during DRAW with a simultaneous step
    apply_reset();
    req = 1'b1;
    tick();
    req        = 1'b0;
    seed_load  = 1'b1;
    seed_value = 9'h155;
    step       = 1'b1;
    tick();
    chk("drawseed_lfsr", lfsr_output, 9'h155);
    chk("drawseed_valid", rsp_valid, 0);
    seed_load = 1'b0;
    tick();
    chk("drawseed_next_compare", lfsr_output, 9'h0AA);
    chk("drawseed_still_draw", req_ready, 0);
    step = 1'b0;
    predict(9'h0AA, v, k);
    wait_rsp(cnt);
    chk("drawseed_latency", cnt, k + 1);
    chk("drawseed_value", rsp_value, v);
    chk("drawseed_lfsr_after", lfsr_output, ref_next(v));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("drawseed_release", req_ready, 1);

    // Zero seed: guarded build forces 1, otherwise the register sticks at 0
    seed_load  = 1'b1;
    seed_value = '0;
    tick();
    seed_load = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
    m = 9'h001;
`else
    m = 9'h000;
`endif
    chk("zero_seed_lfsr", lfsr_output, m);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      m = ref_next(m);
`ifdef LFSR_LOCKUP_GUARD_EN
      if (m == '0) m = 9'h001;
`endif
      chk("zero_seed_step", lfsr_output, m);
    end
    step = 1'b0;

    // Asynchronous reset while VALID, then the range request again
    apply_reset();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    chk("rstvalid_pre_valid", rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk("rstvalid_valid", rsp_valid, 0);
    chk("rstvalid_value", rsp_value, 0);
    chk("rstvalid_ready", req_ready, 1);
    chk("rstvalid_lfsr", lfsr_output, 9'h1FF);
    @(negedge clock);
    reset = 1'b0;
    #1;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("rstvalid_e1_lfsr", lfsr_output, 9'h0FF);
    chk("rstvalid_e1_valid", rsp_valid, 0);
    tick();
    chk("rstvalid_e2_valid", rsp_valid, 1);
    chk("rstvalid_e2_value", rsp_value, 9'h0FF);
    chk("rstvalid_e2_lfsr", lfsr_output, 9'h07F);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Randomized transactions against the sequence-walking model
    apply_reset();
    m = 9'h1FF;
    for (int t = 0; t < 40; t++) begin
      int n;
      int h;
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        step       = 1'($urandom_range(0, 1));
        seed_load  = ($urandom_range(0, 7) == 0);
        seed_value = W'($urandom_range(1, 511));
        tick();
        if (seed_load) m = seed_value;
        else if (step) m = ref_next(m);
        chk("rnd_idle_lfsr", lfsr_output, m);
      end
      idle_inputs();
      req = 1'b1;
      tick();
      req = 1'b0;
      chk("rnd_req_taken", req_ready, 0);
      chk("rnd_draw_lfsr", lfsr_output, m);
      predict(m, v, k);
      wait_rsp(cnt);
      chk("rnd_latency", cnt, k + 1);
      chk("rnd_value", rsp_value, v);
      m = ref_next(v);
      chk("rnd_lfsr_after", lfsr_output, m);
      h = $urandom_range(0, 3);
      for (int i = 0; i < h; i++) begin
        step = 1'($urandom_range(0, 1));
        req  = 1'($urandom_range(0, 1));
        tick();
        if (step) m = ref_next(m);
        chk("rnd_hold_valid", rsp_valid, 1);
        chk("rnd_hold_value", rsp_value, v);
        chk("rnd_hold_lfsr", lfsr_output, m);
      end
      req       = 1'b0;
      step      = 1'($urandom_range(0, 1));
      rsp_ready = 1'b1;
      tick();
      if (step) m = ref_next(m);
      chk("rnd_accept_valid", rsp_valid, 0);
      chk("rnd_accept_ready", req_ready, 1);
      chk("rnd_accept_lfsr", lfsr_output, m);
      idle_inputs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
